// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot with valid/ready handshake.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             d_last,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic             q_last,
    output logic             free
);

    assign free = !valid || ready;

    // Payload only changes on load, so it stays stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            q      <= '0;
            q_last <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            q      <= d;
            q_last <= d_last;
        end else if (ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to2_stream.sv
// Packet-aware 1-to-2 stream demux: route is latched on the first beat.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last
);

    state_t state, state_nxt;
    logic   lock_sel, lock_nxt;
    logic   rsel;
    logic   free0, free1;
    logic   accept;
    logic   load0, load1;

    assign rsel     = (state == ST_IDLE) ? s0 : lock_sel;
    assign in_ready = (rsel == SEL_OUT1) ? free1 : free0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (rsel == SEL_OUT0);
    assign load1    = accept && (rsel == SEL_OUT1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            lock_sel <= SEL_OUT0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_sel;
        unique case (state)
            ST_IDLE: begin
                if (accept && !in_last) begin
                    state_nxt = ST_BUSY;
                    lock_nxt  = s0;
                end
            end
            ST_BUSY: begin
                if (accept && in_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk    (clk),
        .rst    (rst),
        .load   (load0),
        .d      (in_data),
        .d_last (in_last),
        .ready  (out0_ready),
        .valid  (out0_valid),
        .q      (out0_data),
        .q_last (out0_last),
        .free   (free0)
    );

    demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk    (clk),
        .rst    (rst),
        .load   (load1),
        .d      (in_data),
        .d_last (in_last),
        .ready  (out1_ready),
        .valid  (out1_valid),
        .q      (out1_data),
        .q_last (out1_last),
        .free   (free1)
    );

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: vector table, corner sequences, random model.
module tb_demux_1to2_stream;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             s0;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_last;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_last;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_1to2_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s0         (s0),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last)
    );

    typedef struct {
        logic       s0;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_l0;
        logic       e_v1;
        logic [7:0] e_d1;
        logic       e_l1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sel, input logic v, input logic [7:0] d,
                         input logic l, input logic r0, input logic r1);
        s0 = sel; in_valid = v; in_data = d; in_last = l;
        out0_ready = r0; out1_ready = r1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference model: one FIFO of expected beats per output.
    logic [WIDTH:0] q0[$];
    logic [WIDTH:0] q1[$];
    bit             m_busy;
    bit             m_dest;

    initial begin
        logic       route, e_rdy, acc, pop0, pop1, hold;
        logic [WIDTH:0] beat;

        vecs[0] = '{1, 1, 8'hA5, 1, 1, 1,  1, 0, 8'h00, 0, 1, 8'hA5, 1};
        vecs[1] = '{0, 1, 8'h11, 0, 1, 1,  1, 1, 8'h11, 0, 0, 8'h00, 0};
        vecs[2] = '{1, 1, 8'h22, 0, 1, 1,  1, 1, 8'h22, 0, 0, 8'h00, 0};
        vecs[3] = '{1, 1, 8'h33, 1, 1, 1,  1, 1, 8'h33, 1, 0, 8'h00, 0};
        vecs[4] = '{0, 1, 8'h44, 1, 1, 1,  1, 1, 8'h44, 1, 0, 8'h00, 0};
        vecs[5] = '{1, 1, 8'h55, 1, 1, 1,  1, 0, 8'h00, 0, 1, 8'h55, 1};
        vecs[6] = '{0, 1, 8'h66, 1, 0, 1,  1, 1, 8'h66, 1, 0, 8'h00, 0};
        vecs[7] = '{0, 1, 8'h77, 1, 0, 1,  0, 1, 8'h66, 1, 0, 8'h00, 0};
        vecs[8] = '{1, 1, 8'h88, 1, 0, 1,  1, 1, 8'h66, 1, 1, 8'h88, 1};
        vecs[9] = '{0, 0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0};

        rst = 1'b0;
        do_reset();
        chk("reset_v0", out0_valid, 0);
        chk("reset_v1", out1_valid, 0);
        chk("reset_d0", out0_data, 0);
        chk("reset_l1", out1_last, 0);

        // Asynchronous reset while out0 holds a beat.
        drive(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("pre_arst_v0", out0_valid, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_v0", out0_valid, 0);
        chk("arst_v1", out1_valid, 0);
        chk("arst_d0", out0_data, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].s0, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r0, vecs[i].r1);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), in_ready, vecs[i].e_rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_v0", i), out0_valid, vecs[i].e_v0);
            chk($sformatf("vec%0d_v1", i), out1_valid, vecs[i].e_v1);
            if (vecs[i].e_v0) begin
                chk($sformatf("vec%0d_d0", i), out0_data, vecs[i].e_d0);
                chk($sformatf("vec%0d_l0", i), out0_last, vecs[i].e_l0);
            end
            if (vecs[i].e_v1) begin
                chk($sformatf("vec%0d_d1", i), out1_data, vecs[i].e_d1);
                chk($sformatf("vec%0d_l1", i), out1_last, vecs[i].e_l1);
            end
        end

        // 8-beat packet on out1, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 8'(i), (i == 7), 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("burst%0d_rdy", i), in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("burst%0d_v1", i), out1_valid, 1);
            chk($sformatf("burst%0d_d1", i), out1_data, 32'(i));
            chk($sformatf("burst%0d_l1", i), out1_last, (i == 7));
            chk($sformatf("burst%0d_v0", i), out0_valid, 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("burst_end_v1", out1_valid, 0);

        // Reset in the middle of a packet locked to out1.
        drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("midpkt_v1", out1_valid, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("postrst_rdy", in_ready, 1);
        @(posedge clk); #1;
        chk("postrst_v0", out0_valid, 1);
        chk("postrst_d0", out0_data, 8'hC3);
        chk("postrst_v1", out1_valid, 0);
        in_valid = 1'b0;

        // Random traffic against the queue model.
        do_reset();
        q0.delete(); q1.delete();
        m_busy = 0; m_dest = 0;
        hold = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
            end
            s0         = 1'($urandom);
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            route = m_busy ? m_dest : s0;
            pop0  = (q0.size() > 0) && out0_ready;
            pop1  = (q1.size() > 0) && out1_ready;
            e_rdy = route ? (q1.size() == 0 || out1_ready)
                          : (q0.size() == 0 || out0_ready);
            acc   = in_valid && e_rdy;
            chk("rnd_rdy", in_ready, e_rdy);
            chk("rnd_v0", out0_valid, q0.size() > 0);
            chk("rnd_v1", out1_valid, q1.size() > 0);
            if (q0.size() > 0) chk("rnd_b0", {out0_last, out0_data}, q0[0]);
            if (q1.size() > 0) chk("rnd_b1", {out1_last, out1_data}, q1[0]);
            @(posedge clk); #1;
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (acc) begin
                beat = {in_last, in_data};
                if (route) q1.push_back(beat);
                else       q0.push_back(beat);
                if (in_last) m_busy = 0;
                else if (!m_busy) begin
                    m_busy = 1;
                    m_dest = s0;
                end
            end
            hold = in_valid && !acc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
